// File: rtl/ep_memroute.sv
// ep_memroute: routes the core's secondary memory bus to boot ROM, video
// dual-port RAM or the SDRAM controller. Each access stalls the core until
// the selected backend completes; read data is captured into a register.
// Optional build macro: EP_MEMROUTE_P07RAM_EN -- when defined, the upper
// 8 KB of page 8'h07 is served by SDRAM instead of ROM.
`timescale 1ns/1ps
module ep_memroute #(
    parameter int          ADDR_W  = 22,
    parameter logic [7:0]  ROM_TOP = 8'h08,
    parameter logic [7:0]  RAM_LO  = 8'hBC,
    parameter logic [7:0]  VRM_LO  = 8'hFC,
    parameter int          ROM_LAT = 2,
    parameter int          TO_CYC  = 64
) (
    input  logic              clock32,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] a,
    input  logic [7:0]        d,
    output logic [7:0]        q,
    output logic              stall,
    output logic              err,
    output logic [ADDR_W-1:0] oa,
    output logic [7:0]        od,
    input  logic [7:0]        romQ,
    input  logic [7:0]        dprQ,
    output logic              dprW,
    output logic              sdrRd,
    output logic              sdrWr,
    input  logic              sdrAck,
    input  logic [7:0]        sdrQ
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROMW = 3'd1,
        DPRA = 3'd2,
        SDRW = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_ROM  = 2'd1,
        TGT_DPR  = 2'd2,
        TGT_SDR  = 2'd3
    } tgt_t;

    // One counter serves both the ROM latency countdown and the SDRAM timeout.
    localparam logic [9:0] ROM_LOAD = 10'(ROM_LAT - 1);
    localparam logic [9:0] TO_LAST  = 10'(TO_CYC - 1);

    state_t      state_r, state_s;
    tgt_t        tgt_s;
    logic [9:0]  cnt_r, cnt_s;
    logic [7:0]  page_s;
    logic        p07_s;
    logic [7:0]  q_s, od_s;
    logic [ADDR_W-1:0] oa_s;
    logic        err_s, stall_s, dprw_s, sdrrd_s, sdrwr_s;

    assign page_s = a[ADDR_W-1 -: 8];

`ifdef EP_MEMROUTE_P07RAM_EN
    assign p07_s = (page_s == 8'h07) && a[13];
`else
    assign p07_s = 1'b0;
`endif

    // Page decode in priority order: video RAM, SDRAM, ROM, unmapped.
    always_comb begin
        tgt_s = TGT_NONE;
        if (page_s >= VRM_LO) begin
            tgt_s = TGT_DPR;
        end else if (page_s >= RAM_LO) begin
            tgt_s = TGT_SDR;
        end else if (p07_s) begin
            tgt_s = TGT_SDR;
        end else if (page_s < ROM_TOP) begin
            tgt_s = TGT_ROM;
        end else begin
            tgt_s = TGT_NONE;
        end
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        q_s     = q;
        err_s   = err;
        oa_s    = oa;
        od_s    = od;
        dprw_s  = 1'b0;
        sdrrd_s = sdrRd;
        sdrwr_s = sdrWr;
        case (state_r)
            IDLE: begin
                if (rd || wr) begin
                    oa_s  = a;
                    od_s  = d;
                    cnt_s = 10'd0;
                    case (tgt_s)
                        TGT_DPR: begin
                            state_s = DPRA;
                            dprw_s  = wr;
                        end
                        TGT_SDR: begin
                            state_s = SDRW;
                            sdrwr_s = wr;
                            sdrrd_s = ~wr;
                        end
                        TGT_ROM: begin
                            if (wr) begin
                                state_s = DONE;
                            end else begin
                                state_s = ROMW;
                                cnt_s   = ROM_LOAD;
                            end
                        end
                        default: begin
                            state_s = DONE;
                            if (!wr) begin
                                q_s = 8'hFF;
                            end else begin
                                q_s = q;
                            end
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            ROMW: begin
                if (cnt_r == 10'd0) begin
                    q_s     = romQ;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 10'd1;
                end
            end
            DPRA: begin
                // dprW is only high here for a write, so it selects the capture.
                if (!dprW) begin
                    q_s = dprQ;
                end else begin
                    q_s = q;
                end
                state_s = IDLE;
            end
            SDRW: begin
                // Ack is checked first so an ack on the timeout clock wins.
                if (sdrAck) begin
                    if (sdrRd) begin
                        q_s = sdrQ;
                    end else begin
                        q_s = q;
                    end
                    sdrrd_s = 1'b0;
                    sdrwr_s = 1'b0;
                    state_s = IDLE;
                end else if (cnt_r == TO_LAST) begin
                    if (sdrRd) begin
                        q_s = 8'hFF;
                    end else begin
                        q_s = q;
                    end
                    err_s   = 1'b1;
                    sdrrd_s = 1'b0;
                    sdrwr_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + 10'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                sdrrd_s = 1'b0;
                sdrwr_s = 1'b0;
            end
        endcase
        stall_s = (state_s != IDLE);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clock32 or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 10'd0;
            q       <= 8'hFF;
            stall   <= 1'b0;
            err     <= 1'b0;
            oa      <= '0;
            od      <= 8'h00;
            dprW    <= 1'b0;
            sdrRd   <= 1'b0;
            sdrWr   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            q       <= q_s;
            stall   <= stall_s;
            err     <= err_s;
            oa      <= oa_s;
            od      <= od_s;
            dprW    <= dprw_s;
            sdrRd   <= sdrrd_s;
            sdrWr   <= sdrwr_s;
        end
    end

endmodule

// File: tb/tb_ep_memroute.sv
// Bench for ep_memroute: a table of directed accesses with hand-derived
// expectations, a mid-access reset sequence, then random accesses checked
// against a region-level reference model.
`timescale 1ns/1ps
module tb_ep_memroute;

    logic        clock32 = 1'b0;
    logic        reset   = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [21:0] a = 22'h0;
    logic [7:0]  d = 8'h00;
    logic [7:0]  q, od, romQ, dprQ;
    logic        stall, err, dprW, sdrRd, sdrWr;
    logic [21:0] oa;
    logic        sdrAck = 1'b0;
    logic [7:0]  sdrQ = 8'h00;
    logic [7:0]  rom_pipe;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mdl_q;
    logic       mdl_err;

    always #5 clock32 = ~clock32;

    ep_memroute dut (
        .clock32(clock32), .reset(reset), .rd(rd), .wr(wr), .a(a), .d(d),
        .q(q), .stall(stall), .err(err), .oa(oa), .od(od),
        .romQ(romQ), .dprQ(dprQ), .dprW(dprW),
        .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrAck(sdrAck), .sdrQ(sdrQ)
    );

    function automatic logic [7:0] rom_fn(input logic [21:0] x);
        return x[7:0] ^ 8'hE0;
    endfunction
    function automatic logic [7:0] dpr_fn(input logic [21:0] x);
        return x[7:0] ^ 8'h4A;
    endfunction
    function automatic logic [7:0] sdr_fn(input logic [21:0] x);
        return x[7:0] ^ 8'h96;
    endfunction

    // ROM backend: data for an address appears two clocks after it.
    always @(posedge clock32) rom_pipe <= rom_fn(oa);
    assign romQ = rom_pipe;
    // Video RAM backend: data one clock after the address.
    assign dprQ = dpr_fn(oa);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [21:0] ad;
        logic [7:0]  dd;
        int          ack;
        bit          poke;
        logic [7:0]  eq;
        int          est;
        int          edpw;
        int          esdr;
        logic        eerr;
    } vec_t;

    // Runs one access and compares everything observable with the expectations.
    task automatic do_access(input vec_t v, input string tag);
        int cyc = 0, nrd = 0, nwr = 0, ndpw = 0;
        bit done = 0;
        @(negedge clock32);
        rd = v.r; wr = v.w; a = v.ad; d = v.dd;
        @(posedge clock32);
        for (int it = 0; it < 400; it++) begin
            @(negedge clock32);
            if (it == 0) begin rd = 1'b0; wr = 1'b0; end
            if (v.poke && it == 2) begin rd = 1'b1; a = 22'h3F0099; end
            if (v.poke && it == 3) begin rd = 1'b0; a = v.ad; end
            if (!stall) begin done = 1; break; end
            cyc++;
            nrd  += int'(sdrRd);
            nwr  += int'(sdrWr);
            ndpw += int'(dprW);
            sdrAck = (v.ack != 0) && (v.ack == cyc);
            sdrQ   = sdrAck ? sdr_fn(oa) : (8'h5C ^ 8'(cyc));
            @(posedge clock32);
        end
        sdrAck = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " stall_cycles"}, 32'(cyc), 32'(v.est));
        chk({tag, " q"}, 32'(q), 32'(v.eq));
        chk({tag, " err"}, 32'(err), 32'(v.eerr));
        chk({tag, " oa"}, 32'(oa), 32'(v.ad));
        chk({tag, " od"}, 32'(od), 32'(v.dd));
        chk({tag, " dprW_cycles"}, 32'(ndpw), 32'(v.edpw));
        chk({tag, " sdrRd_cycles"}, 32'(nrd), v.w ? 32'd0 : 32'(v.esdr));
        chk({tag, " sdrWr_cycles"}, 32'(nwr), v.w ? 32'(v.esdr) : 32'd0);
        @(negedge clock32);
        chk({tag, " idle_after"}, 32'(stall), 32'd0);
    endtask

    // Reference model: expected outcome from the page map and access kind.
    task automatic model(inout vec_t v);
        logic [7:0] pg;
        int region;  // 0 none, 1 rom, 2 dpr, 3 sdram
        bit to;
        pg = v.ad[21:14];
        if (pg >= 8'hFC) region = 2;
        else if (pg >= 8'hBC) region = 3;
`ifdef EP_MEMROUTE_P07RAM_EN
        else if (pg == 8'h07 && v.ad[13]) region = 3;
`endif
        else if (pg < 8'h08) region = 1;
        else region = 0;
        to = (v.ack == 0) || (v.ack > 64);
        v.edpw = (region == 2 && v.w) ? 1 : 0;
        case (region)
            1: v.est = v.w ? 1 : 2;
            3: v.est = to ? 64 : v.ack;
            default: v.est = 1;
        endcase
        v.esdr = (region == 3) ? v.est : 0;
        if (!v.w) begin
            case (region)
                1: mdl_q = rom_fn(v.ad);
                2: mdl_q = dpr_fn(v.ad);
                3: mdl_q = to ? 8'hFF : sdr_fn(v.ad);
                default: mdl_q = 8'hFF;
            endcase
        end
        if (region == 3 && to) mdl_err = 1'b1;
        v.eq = mdl_q;
        v.eerr = mdl_err;
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 22'h3F0010, 8'h00, 0,  1'b0, 8'h5A, 1,  0, 0,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 22'h2F0000, 8'hA5, 5,  1'b1, 8'h5A, 5,  0, 5,  1'b0};
        tbl[2]  = '{1'b1, 1'b0, 22'h2F0007, 8'h00, 64, 1'b0, 8'h91, 64, 0, 64, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 22'h2F0004, 8'h00, 0,  1'b0, 8'hFF, 64, 0, 64, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 22'h3F0020, 8'h00, 0,  1'b0, 8'h6A, 1,  0, 0,  1'b1};
        tbl[5]  = '{1'b1, 1'b0, 22'h000123, 8'h00, 0,  1'b0, 8'hC3, 2,  0, 0,  1'b1};
        tbl[6]  = '{1'b0, 1'b1, 22'h000123, 8'h77, 0,  1'b0, 8'hC3, 1,  0, 0,  1'b1};
        tbl[7]  = '{1'b1, 1'b0, 22'h200005, 8'h00, 0,  1'b0, 8'hFF, 1,  0, 0,  1'b1};
        tbl[8]  = '{1'b1, 1'b0, 22'h3F0033, 8'h00, 0,  1'b0, 8'h79, 1,  0, 0,  1'b1};
        tbl[9]  = '{1'b1, 1'b1, 22'h3F4000, 8'h11, 0,  1'b0, 8'h79, 1,  1, 0,  1'b1};
        tbl[10] = '{1'b1, 1'b0, 22'h2EC000, 8'h00, 0,  1'b0, 8'hFF, 1,  0, 0,  1'b1};
        tbl[11] = '{1'b1, 1'b0, 22'h020000, 8'h00, 0,  1'b0, 8'hFF, 1,  0, 0,  1'b1};
`ifdef EP_MEMROUTE_P07RAM_EN
        tbl[12] = '{1'b1, 1'b0, 22'h01E000, 8'h00, 3,  1'b0, 8'h96, 3,  0, 3,  1'b1};
`else
        tbl[12] = '{1'b1, 1'b0, 22'h01E000, 8'h00, 3,  1'b0, 8'hE0, 2,  0, 0,  1'b1};
`endif
        tbl[13] = '{1'b0, 1'b1, 22'h2F0001, 8'h3C, 1,  1'b0, tbl[12].eq, 1, 0, 1, 1'b1};

        repeat (3) @(negedge clock32);
        chk("reset q", 32'(q), 32'hFF);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset oa_od", {2'b00, oa, od}, 32'd0);
        chk("reset strobes", {29'd0, dprW, sdrRd, sdrWr}, 32'd0);
        reset = 1'b1;
        @(negedge clock32);

        for (int i = 0; i < 14; i++) begin
            do_access(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset dropped in the middle of an SDRAM read.
        @(negedge clock32);
        rd = 1'b1; a = 22'h2F0010;
        @(posedge clock32);
        @(negedge clock32);
        rd = 1'b0;
        repeat (3) @(posedge clock32);
        #2;
        chk("midrst sdrRd_before", 32'(sdrRd), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst sdrRd", 32'(sdrRd), 32'd0);
        chk("midrst stall", 32'(stall), 32'd0);
        chk("midrst q", 32'(q), 32'hFF);
        chk("midrst err", 32'(err), 32'd0);
        @(negedge clock32);
        reset = 1'b1;
        @(negedge clock32);
        chk("midrst idle", 32'(stall), 32'd0);
        mdl_q = 8'hFF;
        mdl_err = 1'b0;

        // Random accesses against the reference model.
        for (int n = 0; n < 50; n++) begin
            vec_t v;
            int sel, op;
            logic [7:0] pg;
            sel = $urandom_range(0, 3);
            case (sel)
                0: pg = 8'($urandom_range(0, 7));
                1: pg = 8'($urandom_range(8, 8'hBB));
                2: pg = 8'($urandom_range(8'hBC, 8'hFB));
                default: pg = 8'($urandom_range(8'hFC, 8'hFF));
            endcase
            op = $urandom_range(0, 3);
            v.r = (op != 2);
            v.w = (op >= 2);
            v.ad = {pg, 14'($urandom)};
            v.dd = 8'($urandom);
            v.poke = 1'b0;
            case ($urandom_range(0, 11))
                0: v.ack = 0;
                1: v.ack = 64;
                default: v.ack = $urandom_range(1, 9);
            endcase
            model(v);
            do_access(v, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
